// File: rtl/my_tx_framer_pkg.sv
// Shared encodings for the TX framer: FSM states, magic header words,
// flag bit positions and settings-bus register offsets.
package my_tx_framer_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAFE = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  localparam logic [15:0] MAGIC_DEAD = 16'hdead;
  localparam logic [15:0] MAGIC_CAFE = 16'hcafe;

  localparam int FLG_SOP = 0;
  localparam int FLG_EOP = 1;

  localparam int SR_LEN  = 0;
  localparam int SR_CTRL = 1;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 4;

endpackage

// File: rtl/my_tx_framer_fifo.sv
// Sample FIFO in the fifo_cascade style: src_rdy/dst_rdy handshake on both
// sides, synchronous clear, and an occupancy count one bit wider than the
// address so that a completely full FIFO is representable.
module my_tx_framer_fifo #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_src_rdy,
  output logic             in_dst_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src_rdy,
  input  logic             out_dst_rdy,
  output logic [SIZE:0]    occupied
);

  localparam int DEPTH = 2**SIZE;
  localparam logic [SIZE:0] FULL_CNT = (SIZE+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SIZE:0]    wr_ptr;
  logic [SIZE:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign occupied    = wr_ptr - rd_ptr;
  assign in_dst_rdy  = (occupied != FULL_CNT);
  assign out_src_rdy = (occupied != '0);
  assign out_data    = mem[rd_ptr[SIZE-1:0]];
  assign push        = in_src_rdy & in_dst_rdy & ~clear;
  assign pop         = out_src_rdy & out_dst_rdy & ~clear;

  // storage write; the sample memory carries data only and is never reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[SIZE-1:0]] <= in_data;
  end

  // read/write pointers; clear drops everything currently buffered
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/my_tx_framer.sv
// TX framer: buffers raw samples and emits dead/cafe-headed packets of a
// programmable length, starting a packet only once its full payload is
// buffered so the downstream consumer never stalls mid-packet.
module my_tx_framer
  import my_tx_framer_pkg::*;
#(
  parameter int FIFOSIZE = 10,
  parameter int SR_BASE  = 136
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_dat,
  output logic [3:0]  out_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] pkt_seq,
  output logic        busy,
  output logic [31:0] debug
);

  localparam int DEPTH = 2**FIFOSIZE;
  localparam int LW    = 17;
  localparam logic [7:0] ADDR_LEN  = 8'(SR_BASE + SR_LEN);
  localparam logic [7:0] ADDR_CTRL = 8'(SR_BASE + SR_CTRL);

  // a packet can never be longer than the FIFO can hold
  function automatic logic [LW-1:0] clamp_len(input logic [15:0] len);
    if ({1'b0, len} > LW'(DEPTH)) return LW'(DEPTH);
    return {1'b0, len};
  endfunction

  state_t              state, state_nxt;
  logic [15:0]         len_reg;
  logic                enable;
  logic [2:0]          flags;
  logic                clr_pend;
  logic [LW-1:0]       eff_len, len_q, rem;
  logic [15:0]         seq;
  logic [DATA_W-1:0]   dat_p0;
  logic [3:0]          flg_p0;
  logic                vld_p0;
  logic [DATA_W-1:0]   fifo_dat;
  logic                fifo_vld, fifo_space;
  logic [FIFOSIZE:0]   occ;
  logic                occ_ok, slot, do_clr, can_start, last;
  logic                load, pop;
  logic [DATA_W-1:0]   load_dat;
  logic [3:0]          load_flg;
  logic                unused_set_bits;

  assign unused_set_bits = ^set_data[31:16];

  assign eff_len   = clamp_len(len_reg);
  assign occ_ok    = (eff_len != '0) && (LW'(occ) >= eff_len);
  assign slot      = ~vld_p0 | out_ready;
  assign do_clr    = clr_pend & (state == ST_IDLE) & slot;
  assign can_start = enable & occ_ok & ~clr_pend & slot;
  assign last      = (state == ST_PAY) & slot & (rem == LW'(1));

  my_tx_framer_fifo #(.WIDTH(DATA_W), .SIZE(FIFOSIZE)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear       (do_clr),
    .in_data     (in_data),
    .in_src_rdy  (in_valid & in_ready),
    .in_dst_rdy  (fifo_space),
    .out_data    (fifo_dat),
    .out_src_rdy (fifo_vld),
    .out_dst_rdy (pop),
    .occupied    (occ)
  );

  // settings registers; clear only arms clr_pend, the flush itself waits for IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg  <= '0;
      enable   <= 1'b0;
      flags    <= '0;
      clr_pend <= 1'b0;
    end else begin
      if (do_clr) clr_pend <= 1'b0;
      if (set_stb) begin
        case (set_addr)
          ADDR_LEN:  len_reg <= set_data[15:0];
          ADDR_CTRL: begin
            enable <= set_data[CTRL_EN];
            flags  <= set_data[3:1];
            if (set_data[CTRL_CLR]) clr_pend <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: the state names the next word to be loaded
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (can_start) state_nxt = ST_CAFE;
      ST_CAFE: if (slot)      state_nxt = ST_PAY;
      ST_PAY:  if (last)      state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: which word goes into the output register this cycle
  always_comb begin
    load     = 1'b0;
    pop      = 1'b0;
    load_dat = '0;
    load_flg = '0;
    case (state)
      ST_IDLE: if (can_start) begin
        load              = 1'b1;
        load_dat          = {MAGIC_DEAD, 13'b0, flags};
        load_flg[FLG_SOP] = 1'b1;
      end
      ST_CAFE: if (slot) begin
        load     = 1'b1;
        load_dat = {MAGIC_CAFE, seq};
      end
      ST_PAY: if (slot) begin
        load              = 1'b1;
        pop               = 1'b1;
        load_dat          = fifo_dat;
        load_flg[FLG_EOP] = (rem == LW'(1));
      end
      default: ;
    endcase
  end

  // packet length latch, payload countdown and sequence number
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      rem   <= '0;
      seq   <= '0;
    end else begin
      if ((state == ST_IDLE) && can_start) len_q <= eff_len;
      if ((state == ST_CAFE) && slot)      rem   <= len_q;
      if ((state == ST_PAY) && slot)       rem   <= rem - 1'b1;
      if (last)                            seq   <= seq + 1'b1;
      if (do_clr)                          seq   <= '0;
    end
  end

  // output stage p0: holds a word until the sink takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      dat_p0 <= '0;
      flg_p0 <= '0;
    end else if (load) begin
      vld_p0 <= 1'b1;
      dat_p0 <= load_dat;
      flg_p0 <= load_flg;
    end else if (slot) begin
      vld_p0 <= 1'b0;
    end
  end

  assign out_dat   = dat_p0;
  assign out_flags = flg_p0;
  assign out_valid = vld_p0;
  assign pkt_seq   = seq;
  assign busy      = (state != ST_IDLE);
  assign in_ready  = ~rst & fifo_space & ~do_clr;
  assign debug     = {15'b0, occ_ok, enable, clr_pend, vld_p0, in_ready,
                      9'b0, state, 1'b0};

  a_pay_not_empty: assert property (@(posedge clk) disable iff (rst)
    ((state == ST_PAY) && slot) |-> fifo_vld);

endmodule
